// File: rtl/core2axi_pkg.sv
// Shared types and helpers for the outstanding core-to-AXI4 bridge.
package core2axi_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_e;

   // Beat size tied off in the interconnect wrapper: 4 bytes per beat.
   localparam logic [2:0] AXI_SIZE_WORD = 3'b010;

   // Bits needed to name a 32-bit lane inside a dw-bit bus (at least 1).
   function automatic int unsigned lane_width(input int unsigned dw);
      if (dw <= 32) begin
         return 1;
      end
      return $clog2(dw / 32);
   endfunction

   // EXOKAY counts as success; only SLVERR and DECERR flag an error.
   function automatic logic resp_is_err(input resp_e resp);
      return (resp == SLVERR) || (resp == DECERR);
   endfunction

endpackage

// File: rtl/core2axi_lane_fifo.sv
// Small synchronous FIFO holding the 32-bit lane index of each in-flight transaction.
module core2axi_lane_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Occupancy next-state.
   always_comb begin
      cnt_d = cnt_q;
      if (push_i && !pop_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (pop_i && !push_i) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Pointer and occupancy state with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset; only entries between the pointers are ever read.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/core2axi_outstanding.sv
// Core req/gnt/rvalid data port to AXI4 bridge with up to MAX_OUTSTANDING transactions in flight.
// All in-flight transactions share one direction, so responses return in issue order without IDs.
module core2axi_outstanding
   import core2axi_pkg::*;
#(
   parameter int unsigned AXI_ADDR_WIDTH  = 32,
   parameter int unsigned AXI_DATA_WIDTH  = 64,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,

   input  logic                        data_req_i,
   output logic                        data_gnt_o,
   output logic                        data_rvalid_o,
   output logic                        data_err_o,
   input  logic [AXI_ADDR_WIDTH-1:0]   data_addr_i,
   input  logic                        data_we_i,
   input  logic [3:0]                  data_be_i,
   input  logic [31:0]                 data_wdata_i,
   output logic [31:0]                 data_rdata_o,

   output logic [AXI_ADDR_WIDTH-1:0]   aw_addr_o,
   output logic                        aw_valid_o,
   input  logic                        aw_ready_i,
   output logic [AXI_DATA_WIDTH-1:0]   w_data_o,
   output logic [AXI_DATA_WIDTH/8-1:0] w_strb_o,
   output logic                        w_valid_o,
   input  logic                        w_ready_i,
   input  logic [1:0]                  b_resp_i,
   input  logic                        b_valid_i,
   output logic                        b_ready_o,
   output logic [AXI_ADDR_WIDTH-1:0]   ar_addr_o,
   output logic                        ar_valid_o,
   input  logic                        ar_ready_i,
   input  logic [AXI_DATA_WIDTH-1:0]   r_data_i,
   input  logic [1:0]                  r_resp_i,
   input  logic                        r_valid_i,
   output logic                        r_ready_o
);

   localparam int unsigned LANE_W    = lane_width(AXI_DATA_WIDTH);
   localparam int unsigned NUM_LANES = AXI_DATA_WIDTH / 32;
   localparam int unsigned STRB_W    = AXI_DATA_WIDTH / 8;
   localparam int unsigned CNT_W     = $clog2(MAX_OUTSTANDING + 1);

   if (!(AXI_DATA_WIDTH == 32 || AXI_DATA_WIDTH == 64 || AXI_DATA_WIDTH == 128)) begin : gen_bad_dw
      $error("core2axi_outstanding: AXI_DATA_WIDTH must be 32, 64 or 128");
   end
   if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 16) begin : gen_bad_mo
      $error("core2axi_outstanding: MAX_OUTSTANDING must be in 1..16");
   end

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              dir_q, dir_d;
   logic              aw_done_q, aw_done_d;
   logic              w_done_q, w_done_d;

   logic              can_issue, aw_hs, w_hs, gnt;
   logic              rsp_r, rsp_b, rsp;
   logic [LANE_W-1:0] req_lane, head_lane;
   logic              fifo_full, fifo_empty;
   logic [STRB_W-1:0] strb_base;
   resp_e             r_resp, b_resp;

   if (AXI_DATA_WIDTH == 32) begin : gen_lane_narrow
      assign req_lane = '0;
   end else begin : gen_lane_wide
      assign req_lane = data_addr_i[LANE_W+1:2];
   end

   assign r_resp = resp_e'(r_resp_i);
   assign b_resp = resp_e'(b_resp_i);

   // Issue side: direction switches wait for the bridge to drain; full uses the registered count.
   always_comb begin
      can_issue  = data_req_i && (cnt_q < CNT_W'(MAX_OUTSTANDING)) &&
                   ((cnt_q == '0) || (dir_q == data_we_i));
      ar_valid_o = can_issue && !data_we_i;
      aw_valid_o = can_issue && data_we_i && !aw_done_q;
      w_valid_o  = can_issue && data_we_i && !w_done_q;
      aw_hs      = aw_valid_o && aw_ready_i;
      w_hs       = w_valid_o && w_ready_i;
      if (data_we_i) begin
         gnt = can_issue && (aw_done_q || aw_hs) && (w_done_q || w_hs);
      end else begin
         gnt = ar_valid_o && ar_ready_i;
      end
      data_gnt_o = gnt;
      aw_addr_o  = data_addr_i;
      ar_addr_o  = data_addr_i;
      w_data_o   = {NUM_LANES{data_wdata_i}};
      strb_base       = '0;
      strb_base[3:0]  = data_be_i;
      w_strb_o        = strb_base << (4 * req_lane);
   end

   // Response side: accept only the channel matching the in-flight direction, zero-cycle pass-through.
   always_comb begin
      r_ready_o     = (cnt_q != '0) && !dir_q;
      b_ready_o     = (cnt_q != '0) && dir_q;
      rsp_r         = r_valid_i && r_ready_o;
      rsp_b         = b_valid_i && b_ready_o;
      rsp           = rsp_r || rsp_b;
      data_rvalid_o = rsp;
      data_err_o    = 1'b0;
      data_rdata_o  = '0;
      if (rsp_r) begin
         data_err_o   = resp_is_err(r_resp);
         data_rdata_o = r_data_i[32*head_lane +: 32];
      end else if (rsp_b) begin
         data_err_o   = resp_is_err(b_resp);
      end
   end

   // Bookkeeping next-state: in-flight count, direction and per-channel write completion.
   always_comb begin
      cnt_d = cnt_q;
      case ({gnt, rsp})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
      dir_d = gnt ? data_we_i : dir_q;
      if (gnt) begin
         aw_done_d = 1'b0;
         w_done_d  = 1'b0;
      end else begin
         aw_done_d = aw_done_q || aw_hs;
         w_done_d  = w_done_q || w_hs;
      end
   end

   // Bookkeeping registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         dir_q     <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         dir_q     <= dir_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   // Full/empty guards are redundant with cnt_q but keep the FIFO safe if misused.
   core2axi_lane_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (LANE_W)
   ) u_lane_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (gnt && !fifo_full),
      .pop_i   (rsp && !fifo_empty),
      .data_i  (req_lane),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (head_lane)
   );

endmodule

// File: tb/tb_core2axi_outstanding.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a queue-based model of the bridge.
module tb_core2axi_outstanding;

   localparam int MO = 2;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        data_req_i, data_gnt_o, data_rvalid_o, data_err_o, data_we_i;
   logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
   logic [3:0]  data_be_i;
   logic [31:0] aw_addr_o, ar_addr_o;
   logic        aw_valid_o, aw_ready_i, w_valid_o, w_ready_i;
   logic [63:0] w_data_o, r_data_i;
   logic [7:0]  w_strb_o;
   logic [1:0]  b_resp_i, r_resp_i;
   logic        b_valid_i, b_ready_o, ar_valid_o, ar_ready_i, r_valid_i, r_ready_o;

   int n_chk  = 0;
   int n_fail = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   core2axi_outstanding #(
      .AXI_ADDR_WIDTH  (32),
      .AXI_DATA_WIDTH  (64),
      .MAX_OUTSTANDING (MO)
   ) dut (
      .clk_i (clk), .rst_i (rst_i),
      .data_req_i (data_req_i), .data_gnt_o (data_gnt_o), .data_rvalid_o (data_rvalid_o),
      .data_err_o (data_err_o), .data_addr_i (data_addr_i), .data_we_i (data_we_i),
      .data_be_i (data_be_i), .data_wdata_i (data_wdata_i), .data_rdata_o (data_rdata_o),
      .aw_addr_o (aw_addr_o), .aw_valid_o (aw_valid_o), .aw_ready_i (aw_ready_i),
      .w_data_o (w_data_o), .w_strb_o (w_strb_o), .w_valid_o (w_valid_o), .w_ready_i (w_ready_i),
      .b_resp_i (b_resp_i), .b_valid_i (b_valid_i), .b_ready_o (b_ready_o),
      .ar_addr_o (ar_addr_o), .ar_valid_o (ar_valid_o), .ar_ready_i (ar_ready_i),
      .r_data_i (r_data_i), .r_resp_i (r_resp_i), .r_valid_i (r_valid_i), .r_ready_o (r_ready_o)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // Model: an ordered list of in-flight transactions plus whether AW/W of the pending write
   // were already accepted.
   typedef struct packed {
      logic we;
      logic lane;
   } txn_t;

   txn_t m_q[$];
   logic m_aw = 1'b0;
   logic m_w  = 1'b0;
   logic m_gnt = 1'b0;

   always @(negedge clk) begin
      int   cnt;
      logic dir, can, e_arv, e_awv, e_wv, e_gnt, e_rr, e_br, acc_r, acc_b, e_err;
      logic [7:0] e_strb;
      txn_t t;
      if (chk_en) begin
         cnt   = m_q.size();
         dir   = (cnt != 0) ? m_q[0].we : 1'b0;
         can   = data_req_i && (cnt < MO) && (cnt == 0 || dir == data_we_i);
         e_arv = can && !data_we_i;
         e_awv = can && data_we_i && !m_aw;
         e_wv  = can && data_we_i && !m_w;
         e_gnt = data_we_i ? (can && (m_aw || aw_ready_i) && (m_w || w_ready_i))
                           : (e_arv && ar_ready_i);
         e_rr  = (cnt != 0) && !dir;
         e_br  = (cnt != 0) && dir;
         acc_r = r_valid_i && e_rr;
         acc_b = b_valid_i && e_br;
         e_err = acc_r ? r_resp_i[1] : (acc_b ? b_resp_i[1] : 1'b0);
         chk("gnt", data_gnt_o, e_gnt);
         chk("ar_valid", ar_valid_o, e_arv);
         chk("aw_valid", aw_valid_o, e_awv);
         chk("w_valid", w_valid_o, e_wv);
         chk("r_ready", r_ready_o, e_rr);
         chk("b_ready", b_ready_o, e_br);
         chk("rvalid", data_rvalid_o, acc_r || acc_b);
         chk("err", data_err_o, e_err);
         if (acc_r) chk("rdata", data_rdata_o, r_data_i[32*m_q[0].lane +: 32]);
         if (e_arv) chk("ar_addr", ar_addr_o, data_addr_i);
         if (e_awv) chk("aw_addr", aw_addr_o, data_addr_i);
         if (e_wv) begin
            e_strb = {4'b0000, data_be_i} << (data_addr_i[2] ? 4 : 0);
            chk("w_data", w_data_o, {data_wdata_i, data_wdata_i});
            chk("w_strb", w_strb_o, e_strb);
         end
         m_gnt = e_gnt;
         if (rst_i) begin
            m_q.delete();
            m_aw = 1'b0;
            m_w  = 1'b0;
         end else begin
            if (acc_r || acc_b) void'(m_q.pop_front());
            if (e_gnt) begin
               t.we   = data_we_i;
               t.lane = data_addr_i[2];
               m_q.push_back(t);
               m_aw = 1'b0;
               m_w  = 1'b0;
            end else begin
               m_aw = m_aw || (e_awv && aw_ready_i);
               m_w  = m_w || (e_wv && w_ready_i);
            end
         end
      end
   end

   initial begin
      rst_i = 1'b1; data_req_i = 0; data_we_i = 0; data_addr_i = '0; data_be_i = '0;
      data_wdata_i = '0; aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
      b_valid_i = 0; b_resp_i = '0; r_valid_i = 0; r_resp_i = '0; r_data_i = '0;
      @(posedge clk);
      chk_en = 1'b1;
      nxt();
      rst_i = 1'b0; ar_ready_i = 1; aw_ready_i = 1; w_ready_i = 1;
      smp();
      chk("reset_gnt", data_gnt_o, 0);
      chk("reset_rvalid", data_rvalid_o, 0);
      chk("reset_valids", {ar_valid_o, aw_valid_o, w_valid_o}, 0);
      chk("reset_readies", {r_ready_o, b_ready_o, data_err_o}, 0);

      // Single read on lane 1.
      nxt(); data_req_i = 1; data_we_i = 0; data_addr_i = 32'h1004;
      smp(); chk("t1_gnt", data_gnt_o, 1);
      nxt(); data_req_i = 0; r_valid_i = 1; r_data_i = 64'hAAAA_BBBB_1111_2222; r_resp_i = 2'b00;
      smp(); chk("t1_rvalid", data_rvalid_o, 1); chk("t1_rdata", data_rdata_o, 32'hAAAA_BBBB);
      chk("t1_err", data_err_o, 0);
      nxt(); r_valid_i = 0;

      // Write with AW ready delayed 3 cycles.
      data_req_i = 1; data_we_i = 1; data_addr_i = 32'h2000; data_wdata_i = 32'hDEADBEEF;
      data_be_i = 4'hF; aw_ready_i = 0; w_ready_i = 1;
      smp(); chk("t2_c0_gnt", data_gnt_o, 0); chk("t2_c0_wv", w_valid_o, 1);
      chk("t2_strb", w_strb_o, 8'h0F); chk("t2_wdata", w_data_o, 64'hDEADBEEF_DEADBEEF);
      for (int k = 1; k < 3; k++) begin
         nxt(); smp();
         chk("t2_wait_wv", w_valid_o, 0); chk("t2_wait_awv", aw_valid_o, 1);
         chk("t2_wait_gnt", data_gnt_o, 0);
      end
      nxt(); aw_ready_i = 1;
      smp(); chk("t2_c3_gnt", data_gnt_o, 1); chk("t2_c3_wv", w_valid_o, 0);
      nxt(); data_req_i = 0; b_valid_i = 1; b_resp_i = 2'b00;
      smp(); chk("t2_bvalid", data_rvalid_o, 1); chk("t2_berr", data_err_o, 0);
      nxt(); b_valid_i = 0;

      // Four reads against two slots, R held off.
      data_req_i = 1; data_we_i = 0; data_addr_i = 32'h100;
      smp(); chk("t3_g0", data_gnt_o, 1);
      nxt(); data_addr_i = 32'h104;
      smp(); chk("t3_g1", data_gnt_o, 1);
      nxt(); data_addr_i = 32'h108;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) nxt();
         smp(); chk("t3_full_arv", ar_valid_o, 0);
      end
      nxt(); r_valid_i = 1; r_data_i = 64'h2222_2222_1111_1111;
      smp(); chk("t3_r0", data_rdata_o, 32'h1111_1111); chk("t3_r0_arv", ar_valid_o, 0);
      nxt(); r_valid_i = 0;
      smp(); chk("t3_g2", data_gnt_o, 1);
      nxt(); data_addr_i = 32'h10C;
      smp(); chk("t3_full2_arv", ar_valid_o, 0);
      nxt(); r_valid_i = 1; r_data_i = 64'h4444_4444_3333_3333;
      smp(); chk("t3_r1", data_rdata_o, 32'h4444_4444);
      nxt(); r_valid_i = 0;
      smp(); chk("t3_g3", data_gnt_o, 1);
      nxt(); data_req_i = 0; r_valid_i = 1; r_data_i = 64'h6666_6666_5555_5555;
      smp(); chk("t3_r2", data_rdata_o, 32'h5555_5555);
      nxt(); r_data_i = 64'h8888_8888_7777_7777;
      smp(); chk("t3_r3", data_rdata_o, 32'h8888_8888);
      nxt(); r_valid_i = 0;

      // Write, then read blocked until B arrives 5 cycles later; read returns SLVERR.
      data_req_i = 1; data_we_i = 1; data_addr_i = 32'h40; data_wdata_i = 32'h1122_3344;
      smp(); chk("t4_wgnt", data_gnt_o, 1);
      nxt(); data_we_i = 0; data_addr_i = 32'h44;
      for (int k = 1; k <= 5; k++) begin
         if (k > 1) nxt();
         if (k == 5) b_valid_i = 1;
         smp(); chk("t4_arv_blocked", ar_valid_o, 0);
      end
      chk("t4_b_rvalid", data_rvalid_o, 1);
      nxt(); b_valid_i = 0;
      smp(); chk("t4_arv", ar_valid_o, 1); chk("t4_rgnt", data_gnt_o, 1);
      nxt(); data_req_i = 0; r_valid_i = 1; r_data_i = 64'h0BAD_0BAD_1234_5678; r_resp_i = 2'b10;
      smp(); chk("t5_slverr", data_err_o, 1); chk("t5_rdata", data_rdata_o, 32'h0BAD_0BAD);
      nxt(); r_valid_i = 0; r_resp_i = 2'b00;

      // Write on lane 1 answered with DECERR.
      data_req_i = 1; data_we_i = 1; data_addr_i = 32'h3004; data_be_i = 4'h3;
      smp(); chk("t5_strb", w_strb_o, 8'h30); chk("t5_gnt", data_gnt_o, 1);
      nxt(); data_req_i = 0; b_valid_i = 1; b_resp_i = 2'b11;
      smp(); chk("t5_decerr", data_err_o, 1); chk("t5_rvalid", data_rvalid_o, 1);
      nxt(); b_valid_i = 0; b_resp_i = 2'b00;
      smp(); chk("t5_idle", {r_ready_o, b_ready_o}, 2'b00);

      // Reset with two reads in flight.
      nxt(); data_req_i = 1; data_we_i = 0; data_addr_i = 32'h500;
      smp(); chk("t6_g0", data_gnt_o, 1);
      nxt(); data_addr_i = 32'h504;
      smp(); chk("t6_g1", data_gnt_o, 1);
      nxt(); data_req_i = 0; rst_i = 1;
      smp();
      nxt(); rst_i = 0; r_valid_i = 1; r_data_i = 64'hFFFF_FFFF_FFFF_FFFF;
      smp(); chk("t6_no_accept", data_rvalid_o, 0); chk("t6_rready", r_ready_o, 0);
      chk("t6_outs", {ar_valid_o, aw_valid_o, w_valid_o, b_ready_o, data_gnt_o, data_err_o}, 0);
      nxt(); r_valid_i = 0; data_req_i = 1; data_addr_i = 32'h508;
      smp(); chk("t6_gnt", data_gnt_o, 1);
      nxt(); data_req_i = 0; r_valid_i = 1; r_data_i = 64'h7777_7777_9999_9999;
      smp(); chk("t6_rdata", data_rdata_o, 32'h9999_9999);

      // Randomized traffic; the model checks every cycle.
      for (int i = 0; i < 4000; i++) begin
         nxt();
         rst_i = 1'b0;
         if (data_req_i && m_gnt) data_req_i = 0;
         if (!data_req_i && $urandom_range(0, 2) != 0) begin
            data_req_i   = 1;
            data_we_i    = $urandom_range(0, 1) == 1;
            data_addr_i  = $urandom & 32'hFFFF_FFFC;
            data_be_i    = 4'($urandom);
            data_wdata_i = $urandom;
         end
         ar_ready_i = $urandom_range(0, 3) != 0;
         aw_ready_i = $urandom_range(0, 2) != 0;
         w_ready_i  = $urandom_range(0, 2) != 0;
         r_valid_i  = $urandom_range(0, 2) == 0;
         b_valid_i  = $urandom_range(0, 2) == 0;
         r_resp_i   = 2'($urandom);
         b_resp_i   = 2'($urandom);
         r_data_i   = {$urandom, $urandom};
         if ($urandom_range(0, 199) == 0) begin
            rst_i = 1'b1;
            data_req_i = 0;
         end
         smp();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/core2axi_outstanding.md
Name: core2axi_outstanding

Overview:
Successor to the single-transaction core-to-AXI4 data bridge. It converts the core's req/gnt/rvalid data interface into AXI4 AW/W/B/AR/R traffic and keeps up to MAX_OUTSTANDING transactions in flight. AW and W channels are decoupled. It supports AXI data widths of 32, 64 and 128 bits and returns an error flag to the core. It sits between the core LSU and the system AXI interconnect.

Parameters:
AXI_ADDR_WIDTH, 32, address width (the core uses the low 32 bits).
AXI_DATA_WIDTH, 64, AXI data bus width; legal values are 32, 64, 128. Any other value is an elaboration error.
MAX_OUTSTANDING, 4, maximum number of granted-but-unanswered transactions; range 1..16.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
data_req_i  in  1  core request, held stable until granted
data_gnt_o  out  1  request accepted this cycle
data_rvalid_o  out  1  response valid (read data or write ack)
data_err_o  out  1  response was SLVERR or DECERR; qualified by rvalid
data_addr_i  in  AXI_ADDR_WIDTH  byte address
data_we_i  in  1  1 = write
data_be_i  in  4  byte enables
data_wdata_i  in  32  write data
data_rdata_o  out  32  read data, lane-selected
aw_addr_o  out  AXI_ADDR_WIDTH  write address (= data_addr_i)
aw_valid_o  out  1  AW valid
aw_ready_i  in  1  AW ready
w_data_o  out  AXI_DATA_WIDTH  wdata replicated into every 32-bit lane
w_strb_o  out  AXI_DATA_WIDTH/8  data_be_i shifted to the lane
w_valid_o  out  1  W valid
w_ready_i  in  1  W ready
b_resp_i  in  2  write response
b_valid_i  in  1  B valid
b_ready_o  out  1  B ready
ar_addr_o  out  AXI_ADDR_WIDTH  read address (= data_addr_i)
ar_valid_o  out  1  AR valid
ar_ready_i  in  1  AR ready
r_data_i  in  AXI_DATA_WIDTH  read data
r_resp_i  in  2  read response
r_valid_i  in  1  R valid
r_ready_o  out  1  R ready

Behaviour:
- Fixed AXI fields are not ported and are tied in the interconnect wrapper: id=0, len=0, size=3'b010, burst=INCR, w_last=1.
- State:
  - cnt_q: 0..MAX_OUTSTANDING, number in flight.
  - dir_q: 1 = writes in flight.
  - aw_done_q, w_done_q: per-channel completion flags for the current write.
  - Lane FIFO: depth MAX_OUTSTANDING, width LANE_W = max(1, log2(AXI_DATA_WIDTH/32)).
- Reset (rst_i high at a clock edge): cnt_q=0, dir_q=0, flags=0, FIFO empty. While idle every output valid/ready/gnt/rvalid/err is 0.
- Reset mid-operation discards all in-flight bookkeeping. The AXI slave must be reset in the same cycle.
- can_issue = data_req_i && cnt_q<MAX_OUTSTANDING && (cnt_q==0 || dir_q==data_we_i).
  - A direction switch stalls until cnt_q==0. This keeps read-after-write ordering without IDs.
  - A full condition uses the registered count; a pop in the same cycle does not free a slot.
- Read issue: ar_valid_o = can_issue && !data_we_i. data_gnt_o = ar_valid_o && ar_ready_i.
- Write issue:
  - aw_valid_o = can_issue && data_we_i && !aw_done_q.
  - w_valid_o = can_issue && data_we_i && !w_done_q.
  - data_gnt_o when both channels are complete, either handshaked this cycle or via the flag.
  - A channel that handshakes while the other has not sets its flag. Both flags clear on gnt.
- On gnt: push lane = data_addr_i[LANE_W+1:2] (0 when AXI_DATA_WIDTH=32); dir_q <= data_we_i; cnt_q++.
- Responses:
  - r_ready_o = cnt_q!=0 && !dir_q.
  - b_ready_o = cnt_q!=0 && dir_q.
  - data_rvalid_o = (r_valid_i && r_ready_o) || (b_valid_i && b_ready_o). Zero-cycle latency; pops the FIFO; cnt_q--.
  - Push and pop in the same cycle leave cnt_q unchanged.
- data_rdata_o = r_data_i[32*head_lane +: 32]; it is 0 on write responses.
- data_err_o = resp[1] of the accepted response (EXOKAY is treated as OK).
- w_strb_o = data_be_i << (4*lane); all other strobes are 0.
- Minimum latency: gnt in the same cycle as req when ready is high; rvalid one cycle later at the earliest.
- Invariants:
  - A response arriving with cnt_q==0 is never accepted.
  - A write gnt never occurs before both its AW and W handshakes.

Decomposition:
- Package core2axi_pkg:
  - resp_e (OKAY, EXOKAY, SLVERR, DECERR).
  - AXI_SIZE_WORD = 3'b010.
  - The function lane_width(dw).
- One sub-module, core2axi_lane_fifo: a synchronous FIFO parametrised by DEPTH and WIDTH, with push/pop/full/empty/head ports.

Test Plan:
- Read, AXI_DATA_WIDTH=64, addr 0x1004, ar_ready=1; R data 0xAAAA_BBBB_1111_2222 OKAY next cycle -> gnt in cycle 0; rdata 0xAAAA_BBBB and rvalid in cycle 1; err=0.
- Write addr 0x2000, wdata 0xDEADBEEF, be 0xF, aw_ready delayed 3 cycles, w_ready=1 -> W handshakes once; gnt in cycle 3; w_strb=0x0F; B OKAY gives rvalid.
- MAX_OUTSTANDING=2, 4 back-to-back reads, R held off -> 2 gnts, then ar_valid stays low; each R beat frees exactly one slot; data returns in order.
- Write then read with B delayed 5 cycles -> ar_valid stays 0 until the B handshake, then rises the next cycle.
- R resp SLVERR on a read and DECERR on a write -> data_err_o=1 with rvalid for both; cnt_q returns to 0.
- rst_i asserted with 2 reads in flight -> next cycle all outputs 0 and cnt_q=0; a new read issues normally.
